s1_sequenciador_pontos: RTL

- Controller that sequences the end-of-game scoring pass over the per-round error memory (MemErro).
- On `iniciar`, walks addresses 0..num_rodadas-1, reads each round's error count and accumulates a saturating score starting at SCORE_INIT.
- Signals completion with a one-cycle `pronto` pulse.
- Sits between the game control unit, which pulses `iniciar` and waits for `pronto`, and the MemErro read port / score display.

---
 rtl/s1_sequenciador_pontos.sv | 136 +++++++++++++
 1 files changed

// File: rtl/s1_sequenciador_pontos.sv
// Scoring-pass sequencer: reads the per-round error counts from MemErro and
// builds a saturating score, then pulses pronto once the last round is in.
module s1_sequenciador_pontos #(
  parameter int ADDR_W     = 4,
  parameter int ERR_W      = 4,
  parameter int SCORE_W    = 8,
  parameter int SCORE_INIT = 100,
  parameter int PENALTY    = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      iniciar,
  input  logic                      cancelar,
  input  logic [ADDR_W:0]           num_rodadas,
  input  logic [ERR_W-1:0]          mem_dado,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic [SCORE_W-1:0]        pontos,
  output logic [ADDR_W+ERR_W-1:0]   erros_total,
  output logic                      pontos_valido,
  output logic                      ocupado,
  output logic                      pronto,
  output logic [2:0]                db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    LE      = 3'd2,
    ACUMULA = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int PW = ERR_W + SCORE_W;
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  estado_t                  state_q, state_d;
  logic [ADDR_W:0]          n_q, n_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [SCORE_W-1:0]       pontos_q, pontos_d;
  logic [ADDR_W+ERR_W-1:0]  erros_q, erros_d;
  logic                     valido_q, valido_d;
  logic                     rd_q, rd_d;
  logic                     ocupado_q, ocupado_d;
  logic                     pronto_q, pronto_d;
  logic [PW-1:0]            penalty;
  logic [PW-1:0]            pontos_ext;

  // Status strobes are registered from the next state so they line up with it.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    addr_d     = addr_q;
    pontos_d   = pontos_q;
    erros_d    = erros_q;
    valido_d   = valido_q;
    penalty    = PW'(mem_dado) * PW'(PENALTY);
    pontos_ext = PW'(pontos_q);

    if (state_q != OCIOSO && cancelar) begin
      state_d  = OCIOSO;
      valido_d = 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (iniciar && !cancelar) begin
            state_d  = CARREGA;
            n_d      = (num_rodadas > MAX_N) ? MAX_N : num_rodadas;
            pontos_d = SCORE_W'(SCORE_INIT);
            erros_d  = '0;
            addr_d   = '0;
            valido_d = 1'b0;
          end
        end
        CARREGA: state_d = (n_q == '0) ? FIM : LE;
        LE:      state_d = ACUMULA;
        ACUMULA: begin
          // Product is kept wide so a large error count saturates instead of wrapping.
          pontos_d = (pontos_ext > penalty) ? SCORE_W'(pontos_ext - penalty) : '0;
          erros_d  = erros_q + (ADDR_W+ERR_W)'(mem_dado);
          state_d  = PROXIMO;
        end
        PROXIMO: begin
          if ({1'b0, addr_q} == n_q - 1'b1) begin
            state_d = FIM;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = LE;
          end
        end
        FIM:     state_d = OCIOSO;
        default: state_d = OCIOSO;
      endcase
    end

    if (state_d == FIM) valido_d = 1'b1;
    rd_d      = (state_d == LE);
    ocupado_d = (state_d != OCIOSO);
    pronto_d  = (state_d == FIM);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OCIOSO;
      n_q       <= '0;
      addr_q    <= '0;
      pontos_q  <= '0;
      erros_q   <= '0;
      valido_q  <= 1'b0;
      rd_q      <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      addr_q    <= addr_d;
      pontos_q  <= pontos_d;
      erros_q   <= erros_d;
      valido_q  <= valido_d;
      rd_q      <= rd_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_rd        = rd_q;
  assign pontos        = pontos_q;
  assign erros_total   = erros_q;
  assign pontos_valido = valido_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign db_estado     = state_q;

endmodule
